// File: rtl/mm2s_lite_regs_pkg.sv
// mm2s_lite_regs_pkg: register map shared by the MM2S register block and the lite-control master.
// Holds byte offsets, register bit positions, AXI response codes and the offset decoder.
package mm2s_lite_regs_pkg;

    localparam int unsigned AXI_DATA_W  = 32;
    localparam int unsigned AXI_RESP_W  = 2;
    localparam int unsigned MM2S_ADDR_W = 10;
    localparam int unsigned MM2S_LEN_W  = 26;

    // Register byte offsets
    localparam int unsigned DMACR_OFF  = 32'h00;
    localparam int unsigned DMASR_OFF  = 32'h04;
    localparam int unsigned SA_OFF     = 32'h18;
    localparam int unsigned MSB_OFF    = 32'h1C;
    localparam int unsigned LENGTH_OFF = 32'h28;

    // DMACR bits
    localparam int unsigned RS_BIT        = 0;
    localparam int unsigned RESET_BIT     = 2;
    localparam int unsigned IOC_IRQEN_BIT = 12;

    // DMASR bits
    localparam int unsigned HALTED_BIT  = 0;
    localparam int unsigned IDLE_BIT    = 1;
    localparam int unsigned IOC_IRQ_BIT = 12;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_DMACR,
        REG_DMASR,
        REG_SA,
        REG_MSB,
        REG_LENGTH,
        REG_NONE
    } reg_sel_e;

    // Read response payload
    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_RESP_W-1:0] resp;
    } axil_rbeat_t;

    // Byte address -> register select; the two byte-lane bits are ignored.
    function automatic reg_sel_e decode_offset(input logic [31:0] byte_addr);
        reg_sel_e sel;
        case (byte_addr & ~32'h3)
            DMACR_OFF:  sel = REG_DMACR;
            DMASR_OFF:  sel = REG_DMASR;
            SA_OFF:     sel = REG_SA;
            MSB_OFF:    sel = REG_MSB;
            LENGTH_OFF: sel = REG_LENGTH;
            default:    sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mm2s_lite_regs_axi_lite_slave_if.sv
// mm2s_lite_regs_axi_lite_slave_if: AXI4-Lite handshake engine for the MM2S register block.
// Ports: s_axi_lite_* channels; wr_en_c/wr_addr_c/wr_data_c pulse on the edge a write commits,
// wr_err selects SLVERR for it; rd_en_c/rd_addr_c on the AR handshake, rd_data/rd_err captured then.
module mm2s_lite_regs_axi_lite_slave_if
    import mm2s_lite_regs_pkg::*;
#(
    parameter int unsigned ADDR_W = MM2S_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     s_axi_lite_awaddr,
    input  logic                  s_axi_lite_awvalid,
    output logic                  s_axi_lite_awready,
    input  logic [AXI_DATA_W-1:0] s_axi_lite_wdata,
    input  logic                  s_axi_lite_wvalid,
    output logic                  s_axi_lite_wready,
    output logic [AXI_RESP_W-1:0] s_axi_lite_bresp,
    output logic                  s_axi_lite_bvalid,
    input  logic                  s_axi_lite_bready,
    input  logic [ADDR_W-1:0]     s_axi_lite_araddr,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [AXI_DATA_W-1:0] s_axi_lite_rdata,
    output logic [AXI_RESP_W-1:0] s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready,
    output logic                  wr_en_c,
    output logic [ADDR_W-1:0]     wr_addr_c,
    output logic [AXI_DATA_W-1:0] wr_data_c,
    input  logic                  wr_err,
    output logic                  rd_en_c,
    output logic [ADDR_W-1:0]     rd_addr_c,
    input  logic [AXI_DATA_W-1:0] rd_data,
    input  logic                  rd_err
);

    logic                  aw_held_q;
    logic                  w_held_q;
    logic [ADDR_W-1:0]     aw_addr_q;
    logic [AXI_DATA_W-1:0] w_data_q;
    axil_rbeat_t           rbeat_q;

    logic aw_hs_c, w_hs_c;
    logic aw_held_nxt_c, w_held_nxt_c, bvalid_nxt_c, rvalid_nxt_c;

    // Handshake decode; a write commits on the edge where both AW and W are available
    always_comb begin
        aw_hs_c       = s_axi_lite_awvalid & s_axi_lite_awready;
        w_hs_c        = s_axi_lite_wvalid & s_axi_lite_wready;
        wr_en_c       = (aw_held_q | aw_hs_c) & (w_held_q | w_hs_c);
        wr_addr_c     = aw_held_q ? aw_addr_q : s_axi_lite_awaddr;
        wr_data_c     = w_held_q ? w_data_q : s_axi_lite_wdata;
        aw_held_nxt_c = ~wr_en_c & (aw_held_q | aw_hs_c);
        w_held_nxt_c  = ~wr_en_c & (w_held_q | w_hs_c);
        bvalid_nxt_c  = wr_en_c | (s_axi_lite_bvalid & ~s_axi_lite_bready);
        rd_en_c       = s_axi_lite_arvalid & s_axi_lite_arready;
        rd_addr_c     = s_axi_lite_araddr;
        rvalid_nxt_c  = rd_en_c | (s_axi_lite_rvalid & ~s_axi_lite_rready);
    end

    // Channel state; readies are registered from the next-state so they are low in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q          <= 1'b0;
            w_held_q           <= 1'b0;
            aw_addr_q          <= '0;
            w_data_q           <= '0;
            s_axi_lite_awready <= 1'b0;
            s_axi_lite_wready  <= 1'b0;
            s_axi_lite_bvalid  <= 1'b0;
            s_axi_lite_bresp   <= RESP_OKAY;
            s_axi_lite_arready <= 1'b0;
            s_axi_lite_rvalid  <= 1'b0;
            rbeat_q            <= '0;
        end else begin
            aw_held_q          <= aw_held_nxt_c;
            w_held_q           <= w_held_nxt_c;
            if (aw_hs_c) aw_addr_q <= s_axi_lite_awaddr;
            if (w_hs_c)  w_data_q  <= s_axi_lite_wdata;
            s_axi_lite_bvalid  <= bvalid_nxt_c;
            if (wr_en_c) s_axi_lite_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            s_axi_lite_awready <= ~aw_held_nxt_c & ~bvalid_nxt_c;
            s_axi_lite_wready  <= ~w_held_nxt_c & ~bvalid_nxt_c;
            s_axi_lite_rvalid  <= rvalid_nxt_c;
            s_axi_lite_arready <= ~rvalid_nxt_c;
            if (rd_en_c) begin
                rbeat_q.data <= rd_data;
                rbeat_q.resp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    assign s_axi_lite_rdata = rbeat_q.data;
    assign s_axi_lite_rresp = rbeat_q.resp;

endmodule

// File: rtl/mm2s_lite_regs.sv
// mm2s_lite_regs: MM2S channel register file behind an AXI4-Lite responder.
// Ports: clk/rst; s_axi_lite_* AXI4-Lite slave; xfer_start one-cycle start pulse with
// xfer_addr {MSB,SA} and xfer_len (LENGTH); xfer_done completion pulse in; mm2s_introut level irq.
module mm2s_lite_regs
    import mm2s_lite_regs_pkg::*;
#(
    parameter int unsigned ADDR_W = MM2S_ADDR_W,
    parameter int unsigned LEN_W  = MM2S_LEN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     s_axi_lite_awaddr,
    input  logic                  s_axi_lite_awvalid,
    output logic                  s_axi_lite_awready,
    input  logic [AXI_DATA_W-1:0] s_axi_lite_wdata,
    input  logic                  s_axi_lite_wvalid,
    output logic                  s_axi_lite_wready,
    output logic [AXI_RESP_W-1:0] s_axi_lite_bresp,
    output logic                  s_axi_lite_bvalid,
    input  logic                  s_axi_lite_bready,
    input  logic [ADDR_W-1:0]     s_axi_lite_araddr,
    input  logic                  s_axi_lite_arvalid,
    output logic                  s_axi_lite_arready,
    output logic [AXI_DATA_W-1:0] s_axi_lite_rdata,
    output logic [AXI_RESP_W-1:0] s_axi_lite_rresp,
    output logic                  s_axi_lite_rvalid,
    input  logic                  s_axi_lite_rready,
    output logic                  xfer_start,
    output logic [63:0]           xfer_addr,
    output logic [LEN_W-1:0]      xfer_len,
    input  logic                  xfer_done,
    output logic                  mm2s_introut
);

    logic                  wr_en_c, rd_en_c;
    logic [ADDR_W-1:0]     wr_addr_c, rd_addr_c;
    logic [AXI_DATA_W-1:0] wr_data_c, rd_data_c;
    logic                  wr_err_c, rd_err_c, start_c;
    reg_sel_e              wr_sel_c, rd_sel_c;

    logic                  rs_q, ioc_en_q, soft_rst_q, idle_q, ioc_irq_q;
    logic [31:0]           sa_q, msb_q;
    logic [LEN_W-1:0]      len_q;

    mm2s_lite_regs_axi_lite_slave_if #(.ADDR_W(ADDR_W)) u_if (
        .clk                (clk),
        .rst                (rst),
        .s_axi_lite_awaddr  (s_axi_lite_awaddr),
        .s_axi_lite_awvalid (s_axi_lite_awvalid),
        .s_axi_lite_awready (s_axi_lite_awready),
        .s_axi_lite_wdata   (s_axi_lite_wdata),
        .s_axi_lite_wvalid  (s_axi_lite_wvalid),
        .s_axi_lite_wready  (s_axi_lite_wready),
        .s_axi_lite_bresp   (s_axi_lite_bresp),
        .s_axi_lite_bvalid  (s_axi_lite_bvalid),
        .s_axi_lite_bready  (s_axi_lite_bready),
        .s_axi_lite_araddr  (s_axi_lite_araddr),
        .s_axi_lite_arvalid (s_axi_lite_arvalid),
        .s_axi_lite_arready (s_axi_lite_arready),
        .s_axi_lite_rdata   (s_axi_lite_rdata),
        .s_axi_lite_rresp   (s_axi_lite_rresp),
        .s_axi_lite_rvalid  (s_axi_lite_rvalid),
        .s_axi_lite_rready  (s_axi_lite_rready),
        .wr_en_c            (wr_en_c),
        .wr_addr_c          (wr_addr_c),
        .wr_data_c          (wr_data_c),
        .wr_err             (wr_err_c),
        .rd_en_c            (rd_en_c),
        .rd_addr_c          (rd_addr_c),
        .rd_data            (rd_data_c),
        .rd_err             (rd_err_c)
    );

    // Address decode, read mux and start qualification
    always_comb begin
        wr_sel_c  = decode_offset(32'(wr_addr_c));
        rd_sel_c  = decode_offset(32'(rd_addr_c));
        wr_err_c  = (wr_sel_c == REG_NONE);
        rd_err_c  = (rd_sel_c == REG_NONE);
        rd_data_c = '0;
        case (rd_sel_c)
            REG_DMACR: begin
                rd_data_c[RS_BIT]        = rs_q;
                rd_data_c[IOC_IRQEN_BIT] = ioc_en_q;
            end
            REG_DMASR: begin
                rd_data_c[HALTED_BIT]  = ~rs_q;
                rd_data_c[IDLE_BIT]    = idle_q;
                rd_data_c[IOC_IRQ_BIT] = ioc_irq_q;
            end
            REG_SA:     rd_data_c = sa_q;
            REG_MSB:    rd_data_c = msb_q;
            REG_LENGTH: rd_data_c = 32'(len_q);
            default:    rd_data_c = '0;
        endcase
        start_c = wr_en_c && (wr_sel_c == REG_LENGTH) && (|wr_data_c[LEN_W-1:0])
                  && rs_q && idle_q;
    end

    // Register file, start pulse and completion/interrupt status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q         <= 1'b0;
            ioc_en_q     <= 1'b0;
            soft_rst_q   <= 1'b0;
            idle_q       <= 1'b1;
            ioc_irq_q    <= 1'b0;
            sa_q         <= '0;
            msb_q        <= '0;
            len_q        <= '0;
            xfer_start   <= 1'b0;
            mm2s_introut <= 1'b0;
        end else if (soft_rst_q) begin
            // Soft reset lands one cycle after the DMACR write; the B response is unaffected
            rs_q         <= 1'b0;
            ioc_en_q     <= 1'b0;
            soft_rst_q   <= 1'b0;
            idle_q       <= 1'b1;
            ioc_irq_q    <= 1'b0;
            sa_q         <= '0;
            msb_q        <= '0;
            len_q        <= '0;
            xfer_start   <= 1'b0;
            mm2s_introut <= 1'b0;
        end else begin
            xfer_start   <= start_c;
            mm2s_introut <= ioc_irq_q & ioc_en_q;
            if (wr_en_c) begin
                case (wr_sel_c)
                    REG_DMACR: begin
                        rs_q       <= wr_data_c[RS_BIT];
                        ioc_en_q   <= wr_data_c[IOC_IRQEN_BIT];
                        soft_rst_q <= wr_data_c[RESET_BIT];
                    end
                    REG_DMASR:  if (wr_data_c[IOC_IRQ_BIT]) ioc_irq_q <= 1'b0;
                    REG_SA:     sa_q  <= wr_data_c;
                    REG_MSB:    msb_q <= wr_data_c;
                    REG_LENGTH: len_q <= wr_data_c[LEN_W-1:0];
                    default: ;
                endcase
            end
            if (start_c) idle_q <= 1'b0;
            // Completion after the W1C so a coincident set wins
            if (xfer_done) begin
                idle_q    <= 1'b1;
                ioc_irq_q <= 1'b1;
            end
        end
    end

    assign xfer_addr = {msb_q, sa_q};
    assign xfer_len  = len_q;

endmodule

// File: tb/tb_mm2s_lite_regs.sv
// tb_mm2s_lite_regs: directed and randomized bench for mm2s_lite_regs against a register-level model.
module tb_mm2s_lite_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [9:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        xfer_start;
    logic [63:0] xfer_addr;
    logic [25:0] xfer_len;
    logic        xfer_done = 1'b0;
    logic        mm2s_introut;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    // Register-level reference model
    bit        m_rs, m_ien, m_idle, m_irq;
    bit [31:0] m_sa, m_msb;
    bit [25:0] m_len;
    int        m_starts = 0;

    mm2s_lite_regs dut (
        .clk                (clk),
        .rst                (rst),
        .s_axi_lite_awaddr  (awaddr),
        .s_axi_lite_awvalid (awvalid),
        .s_axi_lite_awready (awready),
        .s_axi_lite_wdata   (wdata),
        .s_axi_lite_wvalid  (wvalid),
        .s_axi_lite_wready  (wready),
        .s_axi_lite_bresp   (bresp),
        .s_axi_lite_bvalid  (bvalid),
        .s_axi_lite_bready  (bready),
        .s_axi_lite_araddr  (araddr),
        .s_axi_lite_arvalid (arvalid),
        .s_axi_lite_arready (arready),
        .s_axi_lite_rdata   (rdata),
        .s_axi_lite_rresp   (rresp),
        .s_axi_lite_rvalid  (rvalid),
        .s_axi_lite_rready  (rready),
        .xfer_start         (xfer_start),
        .xfer_addr          (xfer_addr),
        .xfer_len           (xfer_len),
        .xfer_done          (xfer_done),
        .mm2s_introut       (mm2s_introut)
    );

    always #5 clk = ~clk;

    // Each high cycle of xfer_start is counted once
    always @(negedge clk) if (xfer_start === 1'b1) start_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        m_rs = 0; m_ien = 0; m_idle = 1; m_irq = 0;
        m_sa = 0; m_msb = 0; m_len = 0;
    endfunction

    function automatic logic [1:0] m_write(input logic [9:0] a, input logic [31:0] d);
        logic [9:0] word;
        word = {a[9:2], 2'b00};
        case (word)
            10'h000: begin
                if (d[2]) m_reset();
                else begin m_rs = d[0]; m_ien = d[12]; end
            end
            10'h004: if (d[12]) m_irq = 0;
            10'h018: m_sa = d;
            10'h01C: m_msb = d;
            10'h028: begin
                m_len = d[25:0];
                if (m_len != 0 && m_rs && m_idle) begin
                    m_starts++;
                    m_idle = 0;
                end
            end
            default: return 2'b10;
        endcase
        return 2'b00;
    endfunction

    function automatic logic [1:0] m_read(input logic [9:0] a, output logic [31:0] d);
        logic [9:0] word;
        word = {a[9:2], 2'b00};
        d = 32'h0;
        case (word)
            10'h000: d = {19'b0, m_ien, 11'b0, m_rs};
            10'h004: d = {19'b0, m_irq, 10'b0, m_idle, ~m_rs};
            10'h018: d = m_sa;
            10'h01C: d = m_msb;
            10'h028: d = {6'b0, m_len};
            default: return 2'b10;
        endcase
        return 2'b00;
    endfunction

    function automatic void m_done();
        m_idle = 1;
        m_irq  = 1;
    endfunction

    // ---------------- bus drivers ----------------
    task automatic wr_req(input logic [9:0] a, input logic [31:0] d, input int aw_dly, input int w_dly);
        int cyc;
        bit aw_done, w_done, hs_aw, hs_w;
        cyc = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done)) begin
            if (cyc > 60) begin
                total++; bad++;
                $display("FAIL wr_req_timeout addr=%h got=no_handshake want=handshake", a);
                awvalid = 0; wvalid = 0;
                return;
            end
            if (!aw_done && cyc >= aw_dly) begin awaddr = a; awvalid = 1; end
            if (!w_done && cyc >= w_dly) begin wdata = d; wvalid = 1; end
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            if (hs_aw) begin aw_done = 1; awvalid = 0; end
            if (hs_w)  begin w_done = 1;  wvalid = 0; end
            cyc++;
        end
    endtask

    task automatic wr_resp(input int b_dly, output logic [1:0] resp);
        int k;
        bit done;
        k = 0; done = 0; resp = 2'bxx;
        while (!done) begin
            if (k > 60) begin
                total++; bad++;
                $display("FAIL wr_resp_timeout got=no_bvalid want=bvalid");
                bready = 0;
                return;
            end
            bready = (k >= b_dly);
            if (bvalid && bready) begin resp = bresp; done = 1; end
            @(posedge clk); #1;
            k++;
        end
        bready = 0;
    endtask

    task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input int aw_dly,
                             input int w_dly, input int b_dly, output logic [1:0] resp);
        wr_req(a, d, aw_dly, w_dly);
        wr_resp(b_dly, resp);
    endtask

    task automatic rd_req(input logic [9:0] a);
        int cyc;
        bit hs;
        cyc = 0; hs = 0;
        araddr = a; arvalid = 1;
        while (!hs) begin
            if (cyc > 60) begin
                total++; bad++;
                $display("FAIL rd_req_timeout addr=%h got=no_handshake want=handshake", a);
                arvalid = 0;
                return;
            end
            hs = arvalid && arready;
            @(posedge clk); #1;
            cyc++;
        end
        arvalid = 0;
    endtask

    task automatic rd_resp(input int r_dly, output logic [31:0] d, output logic [1:0] resp);
        int k;
        bit done;
        k = 0; done = 0; d = 'x; resp = 2'bxx;
        while (!done) begin
            if (k > 60) begin
                total++; bad++;
                $display("FAIL rd_resp_timeout got=no_rvalid want=rvalid");
                rready = 0;
                return;
            end
            rready = (k >= r_dly);
            if (rvalid && rready) begin d = rdata; resp = rresp; done = 1; end
            @(posedge clk); #1;
            k++;
        end
        rready = 0;
    endtask

    task automatic axi_read(input logic [9:0] a, input int r_dly, output logic [31:0] d,
                            output logic [1:0] resp);
        rd_req(a);
        rd_resp(r_dly, d, resp);
    endtask

    task automatic pulse_done();
        xfer_done = 1;
        @(posedge clk); #1;
        xfer_done = 0;
        m_done();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({awready, wready, arready, bvalid, rvalid, xfer_start, mm2s_introut} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {awready, wready, arready, bvalid, rvalid, xfer_start, mm2s_introut});
        end
        total++;
        if ({bresp, rresp, rdata} !== 36'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {bresp, rresp, rdata});
        end
        rst = 0;
        m_reset();
        @(posedge clk); #1;
        total++;
        if ({awready, wready, arready} !== 3'b111) begin
            bad++;
            $display("FAIL reset_ready_rise got=%b want=111", {awready, wready, arready});
        end
        axi_read(10'h004, 0, d, r);
        total++;
        if (d !== 32'h0000_0003 || r !== 2'b00) begin
            bad++;
            $display("FAIL reset_dmasr got=%h/%b want=00000003/00", d, r);
        end
    endtask

    task automatic test_program();
        logic [31:0] d;
        logic [1:0]  r, racc;
        int s0;
        s0 = start_cnt;
        racc = 2'b00;
        axi_write(10'h000, 32'h0000_1001, 0, 0, 0, r); racc |= r; void'(m_write(10'h000, 32'h1001));
        axi_write(10'h018, 32'h1000_0000, 0, 0, 0, r); racc |= r; void'(m_write(10'h018, 32'h1000_0000));
        axi_write(10'h01C, 32'h0000_0000, 0, 0, 0, r); racc |= r; void'(m_write(10'h01C, 32'h0));
        axi_write(10'h028, 32'h0000_0400, 0, 0, 0, r); racc |= r; void'(m_write(10'h028, 32'h400));
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (racc !== 2'b00) begin bad++; $display("FAIL prog_bresp got=%b want=00", racc); end
        total++;
        if (start_cnt - s0 !== 1) begin
            bad++; $display("FAIL prog_start_pulses got=%0d want=1", start_cnt - s0);
        end
        total++;
        if (xfer_addr !== 64'h0000_0000_1000_0000 || xfer_len !== 26'h400) begin
            bad++; $display("FAIL prog_xfer got=%h/%h want=0000000010000000/400", xfer_addr, xfer_len);
        end
        axi_read(10'h004, 0, d, r);
        total++;
        if (d !== 32'h0 || r !== 2'b00) begin
            bad++; $display("FAIL prog_dmasr got=%h/%b want=00000000/00", d, r);
        end
    endtask

    task automatic test_completion();
        logic [31:0] d;
        logic [1:0]  r;
        pulse_done();
        @(posedge clk); #1;
        total++;
        if (mm2s_introut !== 1'b1) begin bad++; $display("FAIL done_introut got=%b want=1", mm2s_introut); end
        axi_read(10'h004, 0, d, r);
        total++;
        if (d !== 32'h0000_1002) begin bad++; $display("FAIL done_dmasr got=%h want=00001002", d); end
        axi_write(10'h004, 32'h0000_1000, 0, 0, 0, r);
        void'(m_write(10'h004, 32'h1000));
        @(posedge clk); #1;
        total++;
        if (mm2s_introut !== 1'b0) begin bad++; $display("FAIL w1c_introut got=%b want=0", mm2s_introut); end
        // New transfer, then W1C committed on the same edge as xfer_done
        axi_write(10'h028, 32'h0000_0080, 0, 0, 0, r);
        void'(m_write(10'h028, 32'h80));
        awaddr = 10'h004; wdata = 32'h0000_1000;
        awvalid = 1; wvalid = 1; xfer_done = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; xfer_done = 0;
        void'(m_write(10'h004, 32'h1000));
        m_done();
        wr_resp(0, r);
        axi_read(10'h004, 0, d, r);
        total++;
        if (d !== 32'h0000_1002) begin bad++; $display("FAIL done_vs_w1c_dmasr got=%h want=00001002", d); end
        total++;
        if (mm2s_introut !== 1'b1) begin bad++; $display("FAIL done_vs_w1c_introut got=%b want=1", mm2s_introut); end
    endtask

    task automatic test_handshake();
        logic [31:0] d, first;
        logic [1:0]  r;
        axi_write(10'h018, 32'hA5A5_0000, 3, 0, 0, r);
        void'(m_write(10'h018, 32'hA5A5_0000));
        axi_write(10'h01C, 32'h0000_0001, 0, 3, 0, r);
        void'(m_write(10'h01C, 32'h1));
        axi_read(10'h018, 0, d, r);
        total++;
        if (d !== 32'hA5A5_0000) begin bad++; $display("FAIL w_before_aw got=%h want=a5a50000", d); end
        axi_read(10'h01C, 0, d, r);
        total++;
        if (d !== 32'h0000_0001) begin bad++; $display("FAIL aw_before_w got=%h want=00000001", d); end
        // bready stalled: a second write is offered but must not be accepted
        wr_req(10'h018, 32'h1234_5678, 0, 0);
        void'(m_write(10'h018, 32'h1234_5678));
        for (int i = 0; i < 5; i++) begin
            awaddr = 10'h018; wdata = 32'hDEAD_BEEF; awvalid = 1; wvalid = 1;
            total++;
            if ({bvalid, awready, wready} !== 3'b100) begin
                bad++; $display("FAIL b_stall_%0d got=%b want=100", i, {bvalid, awready, wready});
            end
            @(posedge clk); #1;
        end
        awvalid = 0; wvalid = 0;
        wr_resp(0, r);
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL b_stall_resp got=%b want=00", r); end
        axi_read(10'h018, 0, d, r);
        total++;
        if (d !== 32'h1234_5678) begin bad++; $display("FAIL b_stall_data got=%h want=12345678", d); end
        total++;
        if (xfer_addr !== 64'h0000_0001_1234_5678) begin
            bad++; $display("FAIL xfer_addr got=%h want=0000000112345678", xfer_addr);
        end
        // rready stalled: rdata must hold
        rd_req(10'h01C);
        first = rdata;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (rvalid !== 1'b1 || rdata !== 32'h0000_0001) begin
                bad++; $display("FAIL r_stall_%0d got=%b/%h want=1/00000001", i, rvalid, rdata);
            end
            @(posedge clk); #1;
        end
        rd_resp(0, d, r);
        total++;
        if (d !== first) begin bad++; $display("FAIL r_stall_final got=%h want=%h", d, first); end
    endtask

    task automatic test_errors();
        logic [31:0] d, e;
        logic [1:0]  r, er;
        int s0;
        logic [9:0] regs [5];
        regs = '{10'h000, 10'h004, 10'h018, 10'h01C, 10'h028};
        axi_write(10'h03C, 32'hFFFF_FFFF, 0, 0, 0, r);
        total++;
        if (r !== 2'b10) begin bad++; $display("FAIL err_bresp got=%b want=10", r); end
        axi_read(10'h03C, 0, d, r);
        total++;
        if (r !== 2'b10 || d !== 32'h0) begin bad++; $display("FAIL err_read got=%h/%b want=00000000/10", d, r); end
        for (int i = 0; i < 5; i++) begin
            er = m_read(regs[i], e);
            axi_read(regs[i], 0, d, r);
            total++;
            if (d !== e || r !== er) begin
                bad++; $display("FAIL err_unchanged_%h got=%h want=%h", regs[i], d, e);
            end
        end
        // LENGTH whose implemented bits are zero: stored, no start
        s0 = start_cnt;
        axi_write(10'h028, 32'h0400_0000, 0, 0, 0, r);
        void'(m_write(10'h028, 32'h0400_0000));
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (start_cnt !== s0 || xfer_len !== 26'h0) begin
            bad++; $display("FAIL len_zero got=%0d/%h want=%0d/0", start_cnt, xfer_len, s0);
        end
    endtask

    task automatic test_soft_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int s0;
        s0 = start_cnt;
        axi_write(10'h028, 32'h0000_0200, 0, 0, 0, r);
        void'(m_write(10'h028, 32'h200));
        axi_write(10'h000, 32'h0000_1005, 0, 0, 0, r);
        void'(m_write(10'h000, 32'h1005));
        total++;
        if (r !== 2'b00) begin bad++; $display("FAIL srst_bresp got=%b want=00", r); end
        axi_read(10'h018, 0, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL srst_sa got=%h want=0", d); end
        axi_read(10'h028, 0, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL srst_len got=%h want=0", d); end
        axi_read(10'h000, 0, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL srst_dmacr got=%h want=0", d); end
        axi_read(10'h004, 0, d, r);
        total++;
        if (d !== 32'h3) begin bad++; $display("FAIL srst_dmasr got=%h want=3", d); end
        total++;
        if (start_cnt - s0 !== 1 || mm2s_introut !== 1'b0) begin
            bad++; $display("FAIL srst_misc got=%0d/%b want=1/0", start_cnt - s0, mm2s_introut);
        end
    endtask

    task automatic test_random();
        logic [9:0]  addrs [8];
        logic [9:0]  a;
        logic [31:0] d, e;
        logic [1:0]  r, er;
        int op, s0, m0;
        addrs = '{10'h000, 10'h004, 10'h018, 10'h01C, 10'h028, 10'h008, 10'h03C, 10'h100};
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 9));
            a  = addrs[$urandom_range(0, 7)] | 10'($urandom_range(0, 3));
            if (op <= 4) begin
                d = $urandom;
                if ({a[9:2], 2'b00} == 10'h000 && $urandom_range(0, 7) != 0) d[2] = 1'b0;
                if ({a[9:2], 2'b00} == 10'h000 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
                if ({a[9:2], 2'b00} == 10'h028 && $urandom_range(0, 3) == 0) d = d & 32'hFC00_0000;
                s0 = start_cnt; m0 = m_starts;
                er = m_write(a, d);
                axi_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), r);
                @(posedge clk); #1;
                total++;
                if (r !== er || (start_cnt - s0) !== (m_starts - m0)) begin
                    bad++;
                    $display("FAIL rnd_wr_%0d addr=%h got=%b/%0d want=%b/%0d", it, a, r,
                             start_cnt - s0, er, m_starts - m0);
                end
            end else if (op <= 7) begin
                er = m_read(a, e);
                axi_read(a, int'($urandom_range(0, 3)), d, r);
                total++;
                if (d !== e || r !== er) begin
                    bad++; $display("FAIL rnd_rd_%0d addr=%h got=%h/%b want=%h/%b", it, a, d, r, e, er);
                end
            end else begin
                if (!m_idle) pulse_done();
                @(posedge clk); #1;
            end
            total++;
            if (mm2s_introut !== (m_irq & m_ien) || xfer_addr !== {m_msb, m_sa} || xfer_len !== m_len) begin
                bad++;
                $display("FAIL rnd_state_%0d got=%b/%h/%h want=%b/%h/%h", it, mm2s_introut, xfer_addr,
                         xfer_len, m_irq & m_ien, {m_msb, m_sa}, m_len);
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_program();
        test_completion();
        test_handshake();
        test_errors();
        test_soft_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
